// File: rtl/rtc_calendar_core.sv
// Real-time clock/calendar: 1 s prescaler, HH:MM:SS DD/MM/YYYY with Gregorian leap years,
// validated bulk load and 12 h view. Define RTC_ALARM_EN to build the optional alarm.
module rtc_calendar_core #(
    parameter int CLK_HZ   = 1,
    parameter int YEAR_W   = 12,
    parameter int YEAR_MIN = 2020,
    parameter int YEAR_MAX = 2099
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4:0]        ld_hour,
    input  logic [5:0]        ld_min,
    input  logic [5:0]        ld_sec,
    input  logic [4:0]        ld_day,
    input  logic [3:0]        ld_month,
    input  logic [YEAR_W-1:0] ld_year,
    output logic [4:0]        hour,
    output logic [5:0]        min,
    output logic [5:0]        sec,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        disp_hour,
    output logic              pm,
    output logic              sec_pulse,
    output logic              load_err,
    input  logic              alarm_set,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    input  logic              alarm_ack,
    output logic              alarm_ring
);

    localparam int                PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [YEAR_W-1:0] YMIN       = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX       = YEAR_W'(YEAR_MAX);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yy;
        yy = 32'(y);
        return (((yy % 32'd4) == 32'd0) && ((yy % 32'd100) != 32'd0)) || ((yy % 32'd400) == 32'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd2:                    days_in_month = is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic [4:0]        day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              pulse_q, err_q;
    logic              tick, ld_ok, ld_take, adv, al_err;
    logic              c_min, c_hour, c_day, c_month, c_year;

    assign tick    = (presc_q == PRESC_LAST);
    assign ld_ok   = (ld_hour <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59) &&
                     (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                     (ld_day >= 5'd1) && (ld_day <= days_in_month(ld_month, ld_year)) &&
                     (ld_year >= YMIN) && (ld_year <= YMAX);
    assign ld_take = load && ld_ok;
    // A successful load swallows a coinciding tick; a rejected one lets it through.
    assign adv     = tick && !ld_take;
    assign c_min   = adv && (sec_q == 6'd59);
    assign c_hour  = c_min && (min_q == 6'd59);
    assign c_day   = c_hour && (hour_q == 5'd23);
    assign c_month = c_day && (day_q == days_in_month(month_q, year_q));
    assign c_year  = c_month && (month_q == 4'd12);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        if (ld_take) begin
            presc_d = '0;
            hour_d  = ld_hour;
            min_d   = ld_min;
            sec_d   = ld_sec;
            day_d   = ld_day;
            month_d = ld_month;
            year_d  = ld_year;
        end else begin
            if (adv)     sec_d   = c_min   ? 6'd0 : sec_q + 6'd1;
            if (c_min)   min_d   = c_hour  ? 6'd0 : min_q + 6'd1;
            if (c_hour)  hour_d  = c_day   ? 5'd0 : hour_q + 5'd1;
            if (c_day)   day_d   = c_month ? 5'd1 : day_q + 5'd1;
            if (c_month) month_d = c_year  ? 4'd1 : month_q + 4'd1;
            if (c_year)  year_d  = (year_q == YMAX) ? YMIN : year_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= YMIN;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            pulse_q <= adv;
            err_q   <= (load && !ld_ok) || al_err;
        end
    end

`ifdef RTC_ALARM_EN
    logic [4:0] ahour_q, ahour_d;
    logic [5:0] amin_q, amin_d;
    logic       armed_q, armed_d, ring_q, ring_d;
    logic       al_ok, al_match;

    assign al_ok    = (alarm_hour <= 5'd23) && (alarm_min <= 6'd59);
    assign al_err   = alarm_set && !al_ok;
    // Only a real second advance can match, so a load onto the alarm minute never rings.
    assign al_match = adv && armed_q && (sec_d == 6'd0) && (min_d == amin_q) && (hour_d == ahour_q);

    always_comb begin
        ahour_d = ahour_q;
        amin_d  = amin_q;
        armed_d = armed_q;
        ring_d  = ring_q;
        if (alarm_set && al_ok) begin
            ahour_d = alarm_hour;
            amin_d  = alarm_min;
            armed_d = 1'b1;
        end
        if (alarm_ack)     ring_d = 1'b0;
        else if (al_match) ring_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ahour_q <= '0;
            amin_q  <= '0;
            armed_q <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            ahour_q <= ahour_d;
            amin_q  <= amin_d;
            armed_q <= armed_d;
            ring_q  <= ring_d;
        end
    end

    assign alarm_ring = ring_q;
`else
    logic alarm_unused;
    assign alarm_unused = ^{alarm_set, alarm_hour, alarm_min, alarm_ack};
    assign al_err       = 1'b0;
    assign alarm_ring   = 1'b0;
`endif

    always_comb begin
        if (hour_q == 5'd0)       disp_hour = 4'd12;
        else if (hour_q > 5'd12)  disp_hour = 4'(hour_q - 5'd12);
        else                      disp_hour = hour_q[3:0];
    end

    assign pm        = (hour_q >= 5'd12);
    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign sec_pulse = pulse_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Scoreboard bench for rtc_calendar_core: a seconds-of-day/calendar model predicts every
// sec_pulse/load_err event; a negedge monitor pops and compares each one.
module tb_rtc_calendar_core;
    localparam int CLK_HZ = 4;
    localparam int YEAR_W = 12;
    localparam int YMIN   = 2000;
    localparam int YMAX   = 2099;
`ifdef RTC_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, load, alarm_set, alarm_ack;
    logic [4:0]        ld_hour, ld_day, alarm_hour;
    logic [5:0]        ld_min, ld_sec, alarm_min;
    logic [3:0]        ld_month;
    logic [YEAR_W-1:0] ld_year;
    logic [4:0]        hour, day;
    logic [5:0]        min, sec;
    logic [3:0]        month, disp_hour;
    logic [YEAR_W-1:0] year;
    logic              pm, sec_pulse, load_err, alarm_ring;

    rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W), .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
        .clk(clk), .reset(reset), .load(load),
        .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
        .hour(hour), .min(min), .sec(sec), .day(day), .month(month), .year(year),
        .disp_hour(disp_hour), .pm(pm), .sec_pulse(sec_pulse), .load_err(load_err),
        .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_ack(alarm_ack), .alarm_ring(alarm_ring)
    );

    typedef struct {
        int cyc;
        bit pulse;
        bit err;
        int sod;
        int d;
        int mo;
        int y;
        bit ring;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   m_sod, m_d, m_mo, m_y, m_presc, m_ah, m_am;
    bit   m_armed, m_ring;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic bit leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mdays(int mo, int y);
        if (mo == 2) return leap(y) ? 29 : 28;
        return 30 + ((mo + mo / 8) % 2);
    endfunction

    function automatic void next_day();
        m_d++;
        if (m_d > mdays(m_mo, m_y)) begin
            m_d = 1;
            m_mo++;
            if (m_mo > 12) begin
                m_mo = 1;
                m_y  = (m_y == YMAX) ? YMIN : m_y + 1;
            end
        end
    endfunction

    // Advance the model over the coming clock edge with the inputs now applied.
    task automatic step();
        exp_t e;
        bit   tick, lok, lerr, aerr, adv, hit;
        int   h, mi, s, d, mo, y;
        h  = int'(ld_hour);
        mi = int'(ld_min);
        s  = int'(ld_sec);
        d  = int'(ld_day);
        mo = int'(ld_month);
        y  = int'(ld_year);
        if (reset) begin
            m_sod = 0; m_d = 1; m_mo = 1; m_y = YMIN; m_presc = 0;
            m_ah = 0; m_am = 0; m_armed = 0; m_ring = 0;
        end else begin
            tick = (m_presc == CLK_HZ - 1);
            lok  = load && (h < 24) && (mi < 60) && (s < 60) && (mo >= 1) && (mo <= 12) &&
                   (d >= 1) && (d <= mdays(mo, y)) && (y >= YMIN) && (y <= YMAX);
            lerr = load && !lok;
            adv  = tick && !lok;
            aerr = 1'b0;
            hit  = 1'b0;
            if (lok) begin
                m_sod = h * 3600 + mi * 60 + s;
                m_d = d; m_mo = mo; m_y = y; m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % CLK_HZ;
                if (tick) begin
                    m_sod = (m_sod + 1) % 86400;
                    if (m_sod == 0) next_day();
                    hit = m_armed && (m_sod == m_ah * 3600 + m_am * 60);
                end
            end
            if (ALARM) begin
                if (alarm_ack) m_ring = 1'b0;
                else if (hit)  m_ring = 1'b1;
                if (alarm_set) begin
                    if ((alarm_hour < 5'd24) && (alarm_min < 6'd60)) begin
                        m_ah = int'(alarm_hour);
                        m_am = int'(alarm_min);
                        m_armed = 1'b1;
                    end else begin
                        aerr = 1'b1;
                    end
                end
            end
            if (adv || lerr || aerr) begin
                e.cyc = cyc + 1; e.pulse = adv; e.err = lerr || aerr;
                e.sod = m_sod; e.d = m_d; e.mo = m_mo; e.y = m_y; e.ring = m_ring;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 1'b0; load = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            step();
        end
    endtask

    task automatic align_tick();
        while (m_presc != CLK_HZ - 1) idle(1);
    endtask

    task automatic do_load(int h, int mi, int s, int d, int mo, int y);
        set_idle();
        ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
        ld_day = 5'(d); ld_month = 4'(mo); ld_year = YEAR_W'(y);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic rand_load();
        int y, mo, d;
        case ($urandom_range(0, 3))
            0:       y = YMAX;
            1:       y = 2024;
            2:       y = 2023;
            default: y = int'($urandom_range(YMIN - 1, YMAX + 1));
        endcase
        mo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
        d  = ($urandom_range(0, 1) == 0) ? mdays(mo, y) - int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, 31));
        do_load(($urandom_range(0, 1) == 0) ? 23 : int'($urandom_range(0, 24)),
                ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 61)),
                ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 61)),
                d, mo, y);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            nvec++;
            nerr++;
            $display("FAIL missed_event: got no strobe, expected one at cycle %0d", sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (sec_pulse || load_err) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_event: got pulse=%0d err=%0d, expected no strobe (cycle %0d)",
                         sec_pulse, load_err, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("ev_cycle", cyc, mon_e.cyc);
                check("ev_pulse", int'(sec_pulse), mon_e.pulse ? 1 : 0);
                check("ev_err", int'(load_err), mon_e.err ? 1 : 0);
                check("ev_hour", int'(hour), mon_e.sod / 3600);
                check("ev_min", int'(min), (mon_e.sod / 60) % 60);
                check("ev_sec", int'(sec), mon_e.sod % 60);
                check("ev_day", int'(day), mon_e.d);
                check("ev_month", int'(month), mon_e.mo);
                check("ev_year", int'(year), mon_e.y);
                check("ev_disp", int'(disp_hour), ((mon_e.sod / 3600 + 11) % 12) + 1);
                check("ev_pm", int'(pm), (mon_e.sod >= 43200) ? 1 : 0);
                check("ev_ring", int'(alarm_ring), mon_e.ring ? 1 : 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
        ld_hour = '0; ld_min = '0; ld_sec = '0; ld_day = '0; ld_month = '0; ld_year = '0;
        alarm_hour = '0; alarm_min = '0;
        step();
        step();
        set_idle();
        check("rst_hour", int'(hour), 0);
        check("rst_min", int'(min), 0);
        check("rst_sec", int'(sec), 0);
        check("rst_day", int'(day), 1);
        check("rst_month", int'(month), 1);
        check("rst_year", int'(year), YMIN);
        check("rst_pulse", int'(sec_pulse), 0);
        check("rst_err", int'(load_err), 0);
        check("rst_ring", int'(alarm_ring), 0);
        check("rst_disp", int'(disp_hour), 12);
        check("rst_pm", int'(pm), 0);

        do_load(23, 59, 59, 31, 12, 2099); idle(CLK_HZ + 1);
        do_load(23, 59, 59, 28, 2, 2024);  idle(CLK_HZ);
        do_load(23, 59, 59, 28, 2, 2023);  idle(CLK_HZ);
        do_load(23, 59, 59, 28, 2, 2000);  idle(CLK_HZ);
        do_load(23, 59, 59, 29, 2, 2023);  idle(1);
        do_load(12, 0, 0, 31, 4, 2024);    idle(1);
        do_load(25, 0, 0, 1, 1, 2024);     idle(1);
        do_load(10, 0, 0, 1, 1, 1999);     idle(1);
        do_load(11, 59, 59, 1, 1, 2050);   idle(CLK_HZ);
        do_load(12, 59, 59, 1, 1, 2050);   idle(CLK_HZ);

        align_tick();
        do_load(10, 20, 30, 15, 6, 2050);
        check("ldtick_hour", int'(hour), 10);
        check("ldtick_min", int'(min), 20);
        check("ldtick_sec", int'(sec), 30);
        check("ldtick_day", int'(day), 15);
        check("ldtick_month", int'(month), 6);
        check("ldtick_year", int'(year), 2050);
        check("ldtick_pulse", int'(sec_pulse), 0);
        idle(CLK_HZ + 1);

        set_idle(); alarm_hour = 5'd7; alarm_min = 6'd30; alarm_set = 1'b1; step();
        do_load(7, 29, 59, 10, 5, 2030); idle(CLK_HZ);
        set_idle(); alarm_ack = 1'b1; step();
        check("ack_ring", int'(alarm_ring), 0);
        idle(CLK_HZ);
        do_load(7, 29, 59, 10, 5, 2030);
        align_tick();
        set_idle(); alarm_ack = 1'b1; step();
        check("ackmatch_ring", int'(alarm_ring), 0);
        idle(CLK_HZ);
        do_load(7, 29, 59, 10, 5, 2030); idle(CLK_HZ);
        set_idle(); reset = 1'b1; step();
        set_idle();
        check("rstmid_ring", int'(alarm_ring), 0);
        check("rstmid_hour", int'(hour), 0);
        set_idle(); alarm_hour = 5'd24; alarm_min = 6'd0; alarm_set = 1'b1; step();
        idle(2);

        for (int i = 0; i < 700; i++) begin
            set_idle();
            if ($urandom_range(0, 99) < 6) begin
                rand_load();
            end else begin
                if ($urandom_range(0, 39) == 0) begin
                    alarm_set = 1'b1;
                    if ($urandom_range(0, 1) == 0) begin
                        alarm_hour = 5'(m_sod / 3600);
                        alarm_min  = 6'(((m_sod / 60) % 60 + 1) % 60);
                    end else begin
                        alarm_hour = 5'($urandom_range(0, 25));
                        alarm_min  = 6'($urandom_range(0, 61));
                    end
                end
                if ($urandom_range(0, 15) == 0) alarm_ack = 1'b1;
                if ($urandom_range(0, 299) == 0) reset = 1'b1;
                step();
            end
        end

        idle(CLK_HZ + 2);
        #1;
        check("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
